// File: rtl/tick_conditioner_if.sv
// Button-conditioner signal bundle: the raw button level going in and the
// conditioned tick / level / repeat-status coming out.
// The master drives the button; the slave is the conditioner.
interface tick_conditioner_if;
    logic btn_in;
    logic tick;
    logic pressed;
    logic repeating;

    modport master (
        output btn_in,
        input  tick,
        input  pressed,
        input  repeating
    );

    modport slave (
        input  btn_in,
        output tick,
        output pressed,
        output repeating
    );
endinterface

// File: rtl/tick_conditioner.sv
// Push-button conditioner: 2-FF synchroniser -> debounce filter ->
// press-event detector -> optional auto-repeat state machine.
// Produces a clean one-cycle tick per accepted press (and per repeat while
// held), the debounced button level, and a repeat-active flag.
module tick_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic              clk,
    input  logic              rst,
    tick_conditioner_if.slave bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Synchroniser stages
    logic s1_q;
    logic s2_q;

    // Debounce filter
    logic            stable_q;
    logic            stable_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            differ;
    logic            flip;
    logic            rise_evt;
    logic            fall_evt;

    // Press / repeat state machine
    state_t           state_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             tick_q;
    logic             repeating_q;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.btn_in;
            s2_q <= s1_q;
        end
    end

    // Debounce next-state: count consecutive disagreeing cycles, flip the
    // stable level on the last one. The flip strobe doubles as the edge event
    // for the state machine so the tick lands on the same edge as pressed.
    always_comb begin
        differ   = (s2_q != stable_q);
        flip     = differ && (db_cnt_q == DB_LAST);
        rise_evt = flip && s2_q;
        fall_evt = flip && !s2_q;
        stable_d = stable_q;
        db_cnt_d = '0;
        if (flip) begin
            stable_d = s2_q;
            db_cnt_d = '0;
        end else if (differ) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Press/auto-repeat FSM with registered tick and repeating outputs.
    // A tick is only issued when the previous cycle had none, so even with
    // 1-cycle delay/period settings ticks are never back to back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rpt_cnt_q   <= '0;
            tick_q      <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    repeating_q <= 1'b0;
                    if (rise_evt) begin
                        tick_q    <= !tick_q;
                        rpt_cnt_q <= '0;
                        state_q   <= DELAY;
                    end
                end
                DELAY: begin
                    if (fall_evt) begin
                        // Release before the repeat delay expired: no tick.
                        state_q <= IDLE;
                    end else if (!REPEAT_EN) begin
                        // Single-shot mode: wait here for release, counter frozen.
                        rpt_cnt_q <= rpt_cnt_q;
                    end else if (rpt_cnt_q == DELAY_LAST) begin
                        tick_q      <= !tick_q;
                        rpt_cnt_q   <= '0;
                        state_q     <= REPEAT;
                        repeating_q <= 1'b1;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
                    end
                end
                REPEAT: begin
                    if (fall_evt) begin
                        // Release wins over a coinciding period expiry.
                        state_q     <= IDLE;
                        repeating_q <= 1'b0;
                    end else if (rpt_cnt_q == PERIOD_LAST) begin
                        tick_q    <= !tick_q;
                        rpt_cnt_q <= '0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rpt_cnt_q   <= '0;
                    repeating_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tick      = tick_q;
    assign bus.pressed   = stable_q;
    assign bus.repeating = repeating_q;

endmodule
